// File: rtl/game_ctrl.sv
// game_ctrl: round controller for a paddle/shooter game.
// Debounces the start and pause buttons, sequences IDLE/PLAY/PAUSE/HIT/OVER/WIN,
// tracks remaining lives and issues respawn pulses to the game objects.
// Ports:
//   clk, rst (async, active-low)
//   btn_start, btn_pause : raw asynchronous push-buttons
//   frame_tick           : one-clk move strobe at start of vblank
//   player_hit           : level, high while paddle is broken
//   kills[7:0]           : destroyed enemy count
//   run, respawn, lives[1:0], state[2:0], death, win : registered status outputs

// Button conditioner: 2-flop synchronizer, stability counter, rising-edge press.
module game_ctrl_debounce #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press_c
);
  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [1:0]    sync_q;
  logic          db_q, db_n;
  logic [CW-1:0] cnt_q, cnt_n;

  // Level is accepted once the synchronized input has disagreed for CYCLES cycles.
  always_comb begin
    db_n  = db_q;
    cnt_n = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CW'(CYCLES - 1)) begin
        db_n = sync_q[1];
      end else begin
        cnt_n = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      db_q   <= db_n;
      cnt_q  <= cnt_n;
    end
  end

  // Press coincides with the edge on which the debounced level rises.
  assign press_c = db_n & ~db_q;
endmodule

module game_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned KILL_TARGET     = 3,
  parameter int unsigned LIVES           = 3,
  parameter int unsigned HIT_HOLD        = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       frame_tick,
  input  logic       player_hit,
  input  logic [7:0] kills,
  output logic       run,
  output logic       respawn,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       death,
  output logic       win
);
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_HIT   = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  state_t            state_q, state_n;
  logic [1:0]        lives_q, lives_n;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic              hit_d_q;
  logic              respawn_n;
  logic              start_press_c, pause_press_c;
  logic              hit_rise_c;
  logic              kill_win_c;
  logic              hold_done_c;

  game_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk     (clk),
    .rst     (rst),
    .raw     (btn_start),
    .press_c (start_press_c)
  );

  game_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk     (clk),
    .rst     (rst),
    .raw     (btn_pause),
    .press_c (pause_press_c)
  );

  assign hit_rise_c  = player_hit & ~hit_d_q;
  assign kill_win_c  = 32'(kills) >= KILL_TARGET;
  assign hold_done_c = 32'(hold_q) >= HIT_HOLD;

  // Next-state, lives, hold counter and respawn request.
  always_comb begin
    state_n   = state_q;
    lives_n   = lives_q;
    hold_n    = hold_q;
    respawn_n = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_press_c) begin
          lives_n   = 2'(LIVES);
          respawn_n = 1'b1;
          state_n   = S_PLAY;
        end
      end
      S_PLAY: begin
        if (kill_win_c) begin
          state_n = S_WIN;
        end else if (hit_rise_c) begin
          lives_n = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          hold_n  = '0;
          state_n = S_HIT;
        end else if (pause_press_c) begin
          state_n = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_press_c) begin
          state_n = S_PLAY;
        end else if (start_press_c) begin
          state_n = S_IDLE;
        end
      end
      S_HIT: begin
        // Exit is decided from the registered count, one clk after it reaches the hold.
        if (hold_done_c) begin
          if (lives_q == 2'd0) begin
            state_n = S_OVER;
          end else begin
            respawn_n = 1'b1;
            state_n   = S_PLAY;
          end
        end else if (frame_tick) begin
          hold_n = hold_q + HOLD_W'(1);
        end
      end
      S_OVER, S_WIN: begin
        if (start_press_c) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs; status flags follow the next state so they align with state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lives_q <= 2'd0;
      hold_q  <= '0;
      hit_d_q <= 1'b0;
      run     <= 1'b0;
      respawn <= 1'b0;
      death   <= 1'b0;
      win     <= 1'b0;
    end else begin
      state_q <= state_n;
      lives_q <= lives_n;
      hold_q  <= hold_n;
      hit_d_q <= player_hit;
      run     <= (state_n == S_PLAY);
      respawn <= respawn_n;
      death   <= (state_n == S_OVER);
      win     <= (state_n == S_WIN);
    end
  end

  assign state = state_q;
  assign lives = lives_q;
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable clk cycles needed to accept a button level change (10 ms at 100 MHz).
REQ-002 Parameter KILL_TARGET, default 3: enemy-kill count that wins the round.
REQ-003 Parameter LIVES, default 3, legal range 1-3: lives granted at game start.
REQ-004 Parameter HIT_HOLD, default 60: frame_tick pulses spent frozen after the player is hit.
REQ-005 clk  input  1  100 MHz board clock, the only clock; all state is on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (asserted at 0); deassertion is used synchronously by the rest of the design.
REQ-007 btn_start  input  1  raw, asynchronous start push-button, active-high.
REQ-008 btn_pause  input  1  raw, asynchronous pause push-button, active-high.
REQ-009 frame_tick  input  1  one-clk pulse at the start of vertical blanking; this is the game move strobe.
REQ-010 player_hit  input  1  level; high while the paddle is broken.
REQ-011 kills  input  8  unsigned count of destroyed enemies.
REQ-012 run  output  1  enables object movement; feeds the top-level start input.
REQ-013 respawn  output  1  one-clk pulse that restarts all game objects.
REQ-014 lives  output  2  remaining lives.
REQ-015 state  output  3  current FSM state encoding.
REQ-016 death  output  1  high while in OVER.
REQ-017 win  output  1  high while in WIN.

Function
REQ-018 Each button passes through a 2-flop synchronizer, then a debounce counter; the debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles, and any bounce resets the counter to 0.
REQ-019 A press is a one-clk pulse on the 0->1 edge of the debounced level; holding a button generates no further presses.
REQ-020 FSM states and encodings are IDLE=0, PLAY=1, PAUSE=2, HIT=3, OVER=4, WIN=5; codes 6-7 go to IDLE on the next clk.
REQ-021 IDLE: a start press loads lives with LIVES, pulses respawn, and moves to PLAY.
REQ-022 PLAY: the first matching condition applies, in priority order: (a) kills >= KILL_TARGET -> WIN; (b) player_hit rising edge -> decrement lives, clear the hold counter, go to HIT; (c) pause press -> PAUSE.
REQ-023 A start press in PLAY has no effect.
REQ-024 player_hit edge detection uses a registered copy of player_hit, updated every cycle in every state; a level already high on entry to PLAY does not count as a hit.
REQ-025 PAUSE: a pause press -> PLAY; a start press -> IDLE; if both occur in the same cycle, pause takes priority. lives are unchanged.
REQ-026 HIT: the 8-bit hold counter increments on each frame_tick. When the count reaches HIT_HOLD: if lives == 0 -> OVER; otherwise pulse respawn and go to PLAY.
REQ-027 OVER and WIN: a start press -> IDLE. Any other input is ignored.
REQ-028 The lives decrement saturates at 0; lives never wraps to 3.
REQ-029 run = 1 only in PLAY. death = (state == OVER). win = (state == WIN). All three are registered, so they change on the same edge as state.
REQ-030 respawn is registered and is high for exactly one clk per qualifying transition.
REQ-031 kills is compared as an unsigned 8-bit value, zero-extended against KILL_TARGET.

Reset
REQ-032 While rst = 0: state = IDLE, lives = 0, run = 0, respawn = 0, death = 0, win = 0; debounced levels, synchronizers, debounce counters, hold counter and the player_hit delay all = 0.
REQ-033 Reset mid-game (any state) takes effect immediately and asynchronously, with no respawn pulse. After release, the FSM waits in IDLE for a fresh start press.

Verification (DEBOUNCE_CYCLES=4, HIT_HOLD=2, LIVES=3, KILL_TARGET=3)
REQ-034 btn_start toggled every 2 clks for 20 clks, then held high 10 clks -> exactly one start press, state IDLE->PLAY, lives=3, one respawn pulse, run=1.
REQ-035 In PLAY, player_hit 0->1, then 2 frame_ticks -> state HIT with lives=2, then PLAY with one respawn pulse; run=0 throughout HIT.
REQ-036 Three hits, each followed by HIT_HOLD frames -> lives 2,1,0; the final HIT exits to OVER with death=1 and no respawn; a start press then returns to IDLE with death=0.
REQ-037 In PLAY, kills=3 and a player_hit rising edge in the same cycle -> WIN, win=1, lives unchanged.
REQ-038 Pause press in PLAY -> PAUSE, run=0; start and pause pressed in the same cycle -> PLAY; a later start press in PAUSE -> IDLE.
REQ-039 rst driven low for one clk while in HIT with lives=1 -> outputs immediately at reset values; after release, player_hit activity without a start press leaves the FSM in IDLE.
